// File: rtl/div_iter_unit_pkg.sv
// Shared types and sizing for the iterative EX-stage divider.
package div_iter_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = DIV_WIDTH;

endpackage

// File: rtl/div_iter_unit_step.sv
// One restoring radix-2 step: shift the next dividend bit into the partial
// remainder, conditionally subtract the divisor, shift the outcome into quo.
module div_iter_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quoOut
);

  logic [WIDTH:0] remShift;
  logic           fits;

  assign remShift = {remIn, quoIn[WIDTH-1]};
  assign fits     = remShift >= {1'b0, divisor};

  // The difference is always below 2^WIDTH when fits, so the low bits suffice.
  assign remOut = fits ? (remShift[WIDTH-1:0] - divisor) : remShift[WIDTH-1:0];
  assign quoOut = {quoIn[WIDTH-2:0], fits};

endmodule

// File: rtl/div_iter_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU; holds EX via div_stall
// until the result is ready, then keeps HI/LO until the next completion.
//
//   state | meaning
//   IDLE  | waiting for a DIV/DIVU in EX; latches operands on start
//   BUSY  | one restoring step per cycle, WIDTH steps total
//   DONE  | result valid; waits for EX to advance (ext_stall low)
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_validE,
  input  logic             is_signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             flush_exceptionM,
  input  logic             ext_stall,
  output logic             div_stall,
  output logic             div_ready,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divisorReg;
  logic             signQ;
  logic             signR;

  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic             negA;
  logic             negB;

  assign negA = is_signedE & srcaE[WIDTH-1];
  assign negB = is_signedE & srcbE[WIDTH-1];
  assign absA = negA ? (-srcaE) : srcaE;
  assign absB = negB ? (-srcbE) : srcbE;

  div_iter_unit_step #(.WIDTH(WIDTH)) uStep (
    .remIn   (remReg),
    .quoIn   (quoReg),
    .divisor (divisorReg),
    .remOut  (remNext),
    .quoOut  (quoNext)
  );

  assign div_stall = div_validE & (state != DONE) & ~flush_exceptionM;
  assign div_ready = (state == DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      signQ      <= 1'b0;
      signR      <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
    end else if (flush_exceptionM) begin
      // Abort leaves the last committed HI/LO untouched.
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_validE) begin
            remReg     <= '0;
            quoReg     <= absA;
            divisorReg <= absB;
            signQ      <= negA ^ negB;
            signR      <= negA;
            cnt        <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          remReg <= remNext;
          quoReg <= quoNext;
          if (cnt == LAST_CNT) begin
            lo_o  <= signQ ? (-quoNext) : quoNext;
            hi_o  <= signR ? (-remNext) : remNext;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (!ext_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit against an arithmetic reference model.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_validE;
  logic        is_signedE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        flush_exceptionM;
  logic        ext_stall;
  logic        div_stall;
  logic        div_ready;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int          nVec  = 0;
  int          nFail = 0;
  logic [31:0] lastQ = 32'h0;
  logic [31:0] lastR = 32'h0;

  always #5 clk = ~clk;

  div_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .div_validE       (div_validE),
    .is_signedE       (is_signedE),
    .srcaE            (srcaE),
    .srcbE            (srcbE),
    .flush_exceptionM (flush_exceptionM),
    .ext_stall        (ext_stall),
    .div_stall        (div_stall),
    .div_ready        (div_ready),
    .hi_o             (hi_o),
    .lo_o             (lo_o)
  );

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'h0) begin
      q = (sgn && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  // Runs one division; with chain=1 it returns in the last DONE cycle with
  // div_validE still high so the caller's next start lands in the IDLE cycle.
  task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int hold, input bit chain, input string name);
    logic [31:0] eq, er;
    int          stallCnt;
    bit          seen;
    model(a, b, sgn, eq, er);
    @(posedge clk); #1;
    div_validE = 1'b1;
    is_signedE = sgn;
    srcaE      = a;
    srcbE      = b;
    ext_stall  = (hold > 0);
    stallCnt   = 0;
    seen       = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (div_ready === 1'b1) begin
        seen = 1;
        break;
      end
      if (div_stall === 1'b1) stallCnt++;
      if (i > 0) begin
        srcaE      = $urandom;
        srcbE      = $urandom;
        is_signedE = 1'($urandom_range(0, 1));
      end
    end
    nVec++;
    if (!seen) begin
      nFail++;
      $display("FAIL %s timeout: div_ready not seen within 100 cycles", name);
      div_validE = 1'b0;
      ext_stall  = 1'b0;
      return;
    end
    nVec++;
    if (stallCnt != 33) begin
      nFail++;
      $display("FAIL %s stall_cycles: got %0d want 33", name, stallCnt);
    end
    nVec++;
    if (lo_o !== eq || hi_o !== er || div_stall !== 1'b0) begin
      nFail++;
      $display("FAIL %s result a=%h b=%h s=%0d: lo=%h hi=%h stall=%b want lo=%h hi=%h stall=0",
               name, a, b, sgn, lo_o, hi_o, div_stall, eq, er);
    end
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk); #1;
      if (k == hold) ext_stall = 1'b0;
      @(negedge clk);
      nVec++;
      if (div_ready !== 1'b1 || div_stall !== 1'b0 || lo_o !== eq || hi_o !== er) begin
        nFail++;
        $display("FAIL %s hold%0d: ready=%b stall=%b lo=%h hi=%h want ready=1 stall=0 lo=%h hi=%h",
                 name, k, div_ready, div_stall, lo_o, hi_o, eq, er);
      end
    end
    lastQ = eq;
    lastR = er;
    if (!chain) begin
      @(posedge clk); #1;
      div_validE = 1'b0;
      @(negedge clk);
      nVec++;
      if (div_ready !== 1'b0 || div_stall !== 1'b0 || lo_o !== eq || hi_o !== er) begin
        nFail++;
        $display("FAIL %s idle_after: ready=%b stall=%b lo=%h hi=%h want ready=0 stall=0 lo=%h hi=%h",
                 name, div_ready, div_stall, lo_o, hi_o, eq, er);
      end
    end
  endtask

  task automatic test_reset();
    resetn           = 1'b0;
    div_validE       = 1'b0;
    is_signedE       = 1'b0;
    srcaE            = 32'h0;
    srcbE            = 32'h0;
    flush_exceptionM = 1'b0;
    ext_stall        = 1'b0;
    #22;
    nVec++;
    if (div_stall !== 1'b0 || div_ready !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
      nFail++;
      $display("FAIL reset: stall=%b ready=%b hi=%h lo=%h want all 0",
               div_stall, div_ready, hi_o, lo_o);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    runDiv(32'd100, 32'd7, 1'b0, 0, 0, "divu_100_7");
  endtask

  task automatic test_signed();
    runDiv(32'hFFFF_FFF9, 32'h2, 1'b1, 0, 0, "div_m7_2");
    runDiv(32'h7, 32'hFFFF_FFFE, 1'b1, 0, 0, "div_7_m2");
  endtask

  task automatic test_corner();
    runDiv(32'h1234, 32'h0, 1'b0, 0, 0, "divu_by_zero");
    runDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, "div_most_neg");
    runDiv(32'hFFFF_FFF0, 32'h0, 1'b1, 0, 0, "div_neg_by_zero");
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    div_validE = 1'b1;
    is_signedE = 1'b0;
    srcaE      = 32'hDEAD;
    srcbE      = 32'h13;
    repeat (11) @(posedge clk);
    #1;
    flush_exceptionM = 1'b1;
    @(negedge clk);
    nVec++;
    if (div_stall !== 1'b0) begin
      nFail++;
      $display("FAIL flush_mask: stall=%b want 0", div_stall);
    end
    @(posedge clk); #1;
    flush_exceptionM = 1'b0;
    div_validE       = 1'b0;
    @(negedge clk);
    nVec++;
    if (div_ready !== 1'b0 || div_stall !== 1'b0 || lo_o !== lastQ || hi_o !== lastR) begin
      nFail++;
      $display("FAIL flush_idle: ready=%b stall=%b lo=%h hi=%h want ready=0 stall=0 lo=%h hi=%h",
               div_ready, div_stall, lo_o, hi_o, lastQ, lastR);
    end
    runDiv(32'd9, 32'd3, 1'b0, 0, 0, "divu_9_3_after_flush");
  endtask

  task automatic test_ext_stall();
    runDiv(32'd1000, 32'd33, 1'b0, 5, 0, "ext_stall_hold");
  endtask

  task automatic test_back_to_back();
    runDiv(32'd50, 32'd6, 1'b0, 0, 1, "b2b_first");
    runDiv(32'hFFFF_FF00, 32'd5, 1'b1, 1, 1, "b2b_second");
    runDiv(32'd77, 32'd77, 1'b0, 0, 0, "b2b_third");
  endtask

  task automatic test_reset_mid_busy();
    @(posedge clk); #1;
    div_validE = 1'b1;
    is_signedE = 1'b0;
    srcaE      = 32'hFFFF;
    srcbE      = 32'h3;
    repeat (15) @(posedge clk);
    #3;
    resetn     = 1'b0;
    div_validE = 1'b0;
    #1;
    nVec++;
    if (div_stall !== 1'b0 || div_ready !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
      nFail++;
      $display("FAIL reset_mid_busy: stall=%b ready=%b hi=%h lo=%h want all 0",
               div_stall, div_ready, hi_o, lo_o);
    end
    #2;
    resetn = 1'b1;
    lastQ  = 32'h0;
    lastR  = 32'h0;
    runDiv(32'd10, 32'd3, 1'b0, 0, 0, "divu_10_3_after_reset");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        sgn;
    int          mode;
    bit          chain;
    for (int n = 0; n < 24; n++) begin
      mode = $urandom_range(0, 4);
      a    = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case (mode)
        0:       b = $urandom;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'h0;
        3:       b = -($urandom_range(1, 300));
        default: b = a >> $urandom_range(0, 31);
      endcase
      sgn   = 1'($urandom_range(0, 1));
      chain = (n != 23) && ($urandom_range(0, 1) == 1);
      runDiv(a, b, sgn, $urandom_range(0, 2), chain, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_corner();
    test_flush();
    test_ext_stall();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Iterative radix-2 restoring divider in the EX stage; executes MIPS DIV/DIVU.
- Its busy output drives the hazard unit's alu_stallE, which freezes F..W while a division is in flight.
- Result (HI=remainder, LO=quotient) is held stable until the EX instruction advances. Exception flush from M aborts it.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock
- resetn  input  1  asynchronous active-low reset
- div_validE  input  1  EX holds a DIV/DIVU this cycle (already gated by flushE)
- is_signedE  input  1  1=DIV, 0=DIVU
- srcaE  input  WIDTH  dividend (rs)
- srcbE  input  WIDTH  divisor (rt)
- flush_exceptionM  input  1  abort in-flight division
- ext_stall  input  1  d_cache_stall|i_cache_stall; EX cannot advance this cycle
- div_stall  output  1  to hazard alu_stallE
- div_ready  output  1  result valid this cycle
- hi_o  output  WIDTH  remainder
- lo_o  output  WIDTH  quotient

Behaviour:
- States: IDLE, BUSY, DONE. Reset: state=IDLE, cnt=0, internal regs=0, hi_o=lo_o=0, div_ready=0, div_stall=0.
- div_stall is combinational: div_validE & (state!=DONE) & ~flush_exceptionM.
- div_ready = (state==DONE).
- IDLE, div_validE & ~flush_exceptionM:
  - Latch |a|,|b| (absolute values only when is_signedE); latch sign_q=a[31]^b[31] and sign_r=a[31] (both 0 when unsigned).
  - Clear partial remainder; cnt=0; go to BUSY.
- BUSY: one restoring step per cycle.
  - Compute rem' = {rem,q_msb}; if rem'>=divisor, subtract and shift in 1, else shift in 0.
  - cnt increments. The step with cnt==WIDTH-1 registers the final values and goes to DONE.
  - Sign fix-up is applied on that transition: q negated if sign_q; r negated if sign_r.
- Latency: the start cycle plus WIDTH BUSY cycles, so div_stall is high for WIDTH+1=33 consecutive cycles. DONE is entered on the next edge.
- DONE:
  - hi_o/lo_o stable, div_stall=0.
  - Stay in DONE while ext_stall=1.
  - Go to IDLE on the first edge with ext_stall=0, because EX advances then.
  - Outputs hold their values until the next completion.
- Back-to-back: a new div_validE seen in IDLE on the cycle after leaving DONE starts a fresh division.
- flush_exceptionM=1 in any state forces IDLE on the next edge, clears cnt, and masks div_stall in that same cycle. hi_o/lo_o are left unchanged.
- Divide-by-zero (b==0): no trap. Restoring iteration gives q=all ones, r=|a|, then the sign fix-up is applied.
  - Unsigned: lo=0xFFFFFFFF, hi=a.
  - Must not hang.
- Most-negative case: 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0. Wrap-around is accepted.
- Operands are sampled only in the IDLE start cycle. Later changes on srcaE/srcbE during BUSY are ignored.
- resetn low asynchronously returns to reset values from any state.

Decomposition:
- Shared package (pipeline pkg) holds:
  - typedef enum logic[1:0] div_state_t {IDLE, BUSY, DONE}
  - localparam DIV_ITERS=WIDTH
- Optional combinational sub-module div_step: one restoring shift/compare/subtract, taking (rem, quo, divisor) and producing the next (rem, quo). It keeps the FSM file readable.

Test Plan:
1. DIVU 100/7, ext_stall=0 -> div_stall high exactly 33 cycles from the start cycle; then div_ready=1, lo=0x0E, hi=0x02; IDLE on the next edge.
2. DIV -7/2 (0xFFFFFFF9, 0x2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2 -> lo=0xFFFFFFFD, hi=0x1.
3. DIVU 0x1234/0 -> completes in 33 cycles with lo=0xFFFFFFFF, hi=0x1234. Signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Division started, flush_exceptionM pulsed at BUSY cnt=10 -> div_stall low that cycle; IDLE next edge; a new DIVU 9/3 then gives lo=3, hi=0 after a full 33 cycles.
5. ext_stall held high 5 cycles after DONE is reached -> div_ready and hi/lo stay stable 5+1 cycles, div_stall=0 throughout, no restart.
6. resetn dropped mid-BUSY -> all outputs 0 immediately; after release, DIVU 10/3 yields lo=3, hi=1.
